// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the SRAM line packer.
package sram_pkg;

    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_LINE_W = 128;
    localparam int SRAM_DEPTH  = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

endpackage

// File: rtl/sram_line_packer_lanes.sv
// Lane register: assembles WORDS input words into one line, word 0 in the LSBs.
module sram_line_packer_lanes #(
    parameter int IN_W   = 32,
    parameter int WORDS  = 4,
    parameter int LINE_W = IN_W * WORDS,
    parameter int PTR_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [IN_W-1:0]   data_i,
    output logic [LINE_W-1:0] line_nxt_o,
    output logic              line_full_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(WORDS - 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [LINE_W-1:0] line_q;

    // line_nxt_o already contains the word being written this cycle, so the
    // top can register the complete line on the final handshake.
    always_comb begin
        line_nxt_o = line_q;
        ptr_d      = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (wr_en_i) begin
            line_nxt_o[ptr_q*IN_W +: IN_W] = data_i;
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    assign line_full_o = wr_en_i && !clr_i && (ptr_q == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q  <= '0;
            line_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            line_q <= line_nxt_o;
        end
    end

endmodule

// File: rtl/sram_line_packer.sv
// Packs a 32-bit word stream into 128-bit lines and issues one SRAM write per line.
module sram_line_packer
    import sram_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int LINE_W = SRAM_LINE_W,
    parameter int WORDS  = 4,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int CNT_W  = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_lines,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [LINE_W-1:0] sram_d,
    output logic              busy,
    output logic              done
);

    packer_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cen_q, wen_q;
    logic [ADDR_W-1:0] a_q;
    logic [LINE_W-1:0] d_q;

    logic              hs;
    logic              lane_clr;
    logic              line_full;
    logic [LINE_W-1:0] line_nxt;
    logic              wr_d;

    sram_line_packer_lanes #(
        .IN_W   (IN_W),
        .WORDS  (WORDS),
        .LINE_W (LINE_W)
    ) u_lanes (
        .CLK         (CLK),
        .RST         (RST),
        .clr_i       (lane_clr),
        .wr_en_i     (hs),
        .data_i      (in_data),
        .line_nxt_o  (line_nxt),
        .line_full_o (line_full)
    );

    assign in_ready = (state_q == FILL);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign hs       = in_valid && in_ready && !abort;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        lane_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    cnt_d   = num_lines;
                    state_d = (num_lines == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d  = IDLE;
                    lane_clr = 1'b1;
                end else if (line_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d  = IDLE;
                    lane_clr = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == CNT_W'(1)) ? DONE : FILL;
                end
            end
            DONE: begin
                state_d  = IDLE;
                lane_clr = abort;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered on entry to WRITE so they line up with the state.
    assign wr_d = (state_d == WRITE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            cen_q   <= !wr_d;
            wen_q   <= !wr_d;
            if (wr_d) begin
                a_q <= addr_q;
                d_q <= line_nxt;
            end
        end
    end

    assign sram_cen = cen_q;
    assign sram_wen = wen_q;
    assign sram_a   = a_q;
    assign sram_d   = d_q;

endmodule

// File: tb/tb_sram_line_packer.sv
// Directed bench for sram_line_packer: each task drives one scenario and checks inline.
module tb_sram_line_packer;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start, abort;
    logic [10:0]   base_addr;
    logic [11:0]   num_lines;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          sram_cen, sram_wen;
    logic [10:0]   sram_a;
    logic [127:0]  sram_d;
    logic          busy, done;

    int checks = 0;
    int errors = 0;
    int wr_n   = 0;
    int done_n = 0;
    logic [10:0]  wr_a [64];
    logic [127:0] wr_dat [64];

    sram_line_packer dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // SRAM capture model: a write is taken on the rising edge while both strobes are low.
    always @(posedge CLK) begin
        if (!sram_cen && !sram_wen) begin
            wr_a[wr_n % 64]   <= sram_a;
            wr_dat[wr_n % 64] <= sram_d;
            wr_n              <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, required finish before 200000");
        $fatal(1);
    end

    task automatic send_word(input logic [31:0] d, output bit ok);
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(posedge CLK);
                @(negedge CLK);
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic launch(input logic [10:0] b, input logic [11:0] n);
        @(negedge CLK);
        base_addr = b;
        num_lines = n;
        start     = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        start = 0; abort = 0; base_addr = 0; num_lines = 0; in_data = 0; in_valid = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({in_ready, sram_cen, sram_wen, busy, done} !== 5'b01100 || sram_a !== 11'd0 || sram_d !== 128'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/cen/wen/busy/done=%b a=%0d d=%h, required 01100 a=0 d=0",
                     {in_ready, sram_cen, sram_wen, busy, done}, sram_a, sram_d);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic;
        bit ok, all_ok;
        int w0, d0;
        all_ok = 1;
        w0 = wr_n; d0 = done_n;
        launch(11'd5, 12'd2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_fill_entry: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        for (int k = 1; k <= 4; k++) begin send_word(32'(k), ok); all_ok &= ok; end
        checks++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_a !== 11'd5 ||
            sram_d !== 128'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL basic_write0: got cen=%b wen=%b a=%0d d=%h, required 0 0 a=5 d=00000004000000030000000200000001",
                     sram_cen, sram_wen, sram_a, sram_d);
        end
        for (int k = 5; k <= 8; k++) begin send_word(32'(k), ok); all_ok &= ok; end
        in_valid = 1'b0;
        checks++;
        if (sram_cen !== 1'b0 || sram_a !== 11'd6 ||
            sram_d !== 128'h00000008_00000007_00000006_00000005 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_write1: got cen=%b a=%0d d=%h done=%b, required 0 a=6 d=00000008000000070000000600000005 done=0",
                     sram_cen, sram_a, sram_d, done);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || sram_cen !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b cen=%b in_ready=%b, required 1 1 0", done, sram_cen, in_ready);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_n - w0 != 2 || done_n - d0 != 1) begin
            errors++;
            $display("FAIL basic_end: got done=%b busy=%b writes=%0d dones=%0d, required 0 0 2 1",
                     done, busy, wr_n - w0, done_n - d0);
        end
        checks++;
        if (wr_a[w0 % 64] !== 11'd5 || wr_a[(w0 + 1) % 64] !== 11'd6) begin
            errors++;
            $display("FAIL basic_log_addr: got %0d,%0d required 5,6", wr_a[w0 % 64], wr_a[(w0 + 1) % 64]);
        end
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL basic_handshake_timeout: got timeout=1 required 0");
        end
    endtask

    task automatic test_backpressure;
        bit ok, all_ok;
        all_ok = 1;
        launch(11'd20, 12'd1);
        for (int k = 0; k < 4; k++) begin
            send_word(32'hA0 + 32'(k), ok);
            all_ok &= ok;
            if (k < 3) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                @(negedge CLK);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || sram_cen !== 1'b0 || sram_a !== 11'd20 ||
            sram_d !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++;
            $display("FAIL gaps_write: got rdy=%b cen=%b a=%0d d=%h, required 0 0 a=20 d=000000a3000000a2000000a1000000a0",
                     in_ready, sram_cen, sram_a, sram_d);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || !all_ok) begin
            errors++;
            $display("FAIL gaps_end: got busy=%b ok=%b, required 0 1", busy, all_ok);
        end
    endtask

    task automatic test_wrap;
        bit ok, all_ok;
        all_ok = 1;
        launch(11'd2047, 12'd2);
        for (int k = 0; k < 4; k++) begin send_word(32'h11 + 32'(k), ok); all_ok &= ok; end
        checks++;
        if (sram_cen !== 1'b0 || sram_a !== 11'd2047) begin
            errors++;
            $display("FAIL wrap_first: got cen=%b a=%0d, required 0 a=2047", sram_cen, sram_a);
        end
        for (int k = 4; k < 8; k++) begin send_word(32'h11 + 32'(k), ok); all_ok &= ok; end
        in_valid = 1'b0;
        checks++;
        if (sram_cen !== 1'b0 || sram_a !== 11'd0 ||
            sram_d !== 128'h00000018_00000017_00000016_00000015 || !all_ok) begin
            errors++;
            $display("FAIL wrap_second: got cen=%b a=%0d d=%h ok=%b, required 0 a=0 d=00000018000000170000001600000015 ok=1",
                     sram_cen, sram_a, sram_d, all_ok);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_zero_count;
        int w0;
        w0 = wr_n;
        launch(11'd7, 12'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b rdy=%b, required 1 1 0", done, busy, in_ready);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_n != w0) begin
            errors++;
            $display("FAIL zero_end: got done=%b busy=%b writes=%0d, required 0 0 0", done, busy, wr_n - w0);
        end
    endtask

    task automatic test_abort;
        bit ok, all_ok;
        int w0, d0;
        all_ok = 1;
        w0 = wr_n; d0 = done_n;
        launch(11'd30, 12'd1);
        send_word(32'hB0, ok); all_ok &= ok;
        send_word(32'hB1, ok); all_ok &= ok;
        abort   = 1'b1;
        in_data = 32'hB2;
        @(negedge CLK);
        abort    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b rdy=%b, required 0 0", busy, in_ready);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_n != w0 || done_n != d0) begin
            errors++;
            $display("FAIL abort_no_write: got writes=%0d dones=%0d, required 0 0", wr_n - w0, done_n - d0);
        end
        launch(11'd10, 12'd1);
        for (int k = 0; k < 4; k++) begin send_word(32'hC0 + 32'(k), ok); all_ok &= ok; end
        in_valid = 1'b0;
        checks++;
        if (sram_a !== 11'd10 || sram_d !== 128'h000000C3_000000C2_000000C1_000000C0 || !all_ok) begin
            errors++;
            $display("FAIL abort_restart: got a=%0d d=%h ok=%b, required a=10 d=000000c3000000c2000000c1000000c0 ok=1",
                     sram_a, sram_d, all_ok);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_start_ignored;
        bit ok, all_ok;
        all_ok = 1;
        launch(11'd50, 12'd1);
        send_word(32'hD0, ok); all_ok &= ok;
        base_addr = 11'd99;
        num_lines = 12'd0;
        start     = 1'b1;
        send_word(32'hD1, ok); all_ok &= ok;
        start = 1'b0;
        send_word(32'hD2, ok); all_ok &= ok;
        send_word(32'hD3, ok); all_ok &= ok;
        in_valid = 1'b0;
        checks++;
        if (sram_cen !== 1'b0 || sram_a !== 11'd50 ||
            sram_d !== 128'h000000D3_000000D2_000000D1_000000D0 || !all_ok) begin
            errors++;
            $display("FAIL start_ignored: got cen=%b a=%0d d=%h ok=%b, required 0 a=50 d=000000d3000000d2000000d1000000d0 ok=1",
                     sram_cen, sram_a, sram_d, all_ok);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_async_reset;
        bit ok, all_ok;
        int w0;
        all_ok = 1;
        launch(11'd40, 12'd1);
        send_word(32'hE0, ok); all_ok &= ok;
        send_word(32'hE1, ok); all_ok &= ok;
        in_valid = 1'b0;
        w0 = wr_n;
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({in_ready, sram_cen, sram_wen, busy, done} !== 5'b01100 || sram_a !== 11'd0 ||
            sram_d !== 128'd0 || !all_ok) begin
            errors++;
            $display("FAIL async_reset: got rdy/cen/wen/busy/done=%b a=%0d d=%h ok=%b, required 01100 a=0 d=0 ok=1",
                     {in_ready, sram_cen, sram_wen, busy, done}, sram_a, sram_d, all_ok);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || wr_n != w0) begin
            errors++;
            $display("FAIL async_reset_after: got busy=%b writes=%0d, required 0 0", busy, wr_n - w0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_line_packer.md
Name: sram_line_packer

Overview:
Write-side feeder for the 128b x 2048 activation/weight SRAM macro wrapper.
- Accepts a stream of 32-bit words over a valid/ready handshake.
- Packs every 4 consecutive words into one 128-bit line.
- Issues one SRAM write per line to consecutive addresses, starting at a programmed base address, until a programmed line count is reached.
- Sits between the off-chip/testbench loader (or OFIFO drain) and the SRAM's CEN/WEN/A/D pins.

Parameters:
IN_W, 32, input word width in bits
LINE_W, 128, SRAM line width in bits; must equal IN_W*WORDS
WORDS, 4, words packed per line (LINE_W/IN_W)
ADDR_W, 11, SRAM address width (2048 lines)
CNT_W, 12, width of line-count field (allows 0..2048)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; launches a transfer when idle
abort  in  1  synchronous; discards the partial line and returns to IDLE
base_addr  in  ADDR_W  first SRAM line address, sampled on accepted start
num_lines  in  CNT_W  lines to write, sampled on accepted start
in_data  in  IN_W  input word
in_valid  in  1  in_data valid
in_ready  out  1  packer can accept in_data this cycle
sram_cen  out  1  SRAM chip enable, active low, registered
sram_wen  out  1  SRAM write enable, active low, registered
sram_a  out  ADDR_W  SRAM address, registered
sram_d  out  LINE_W  SRAM write data, registered
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the final line write has been issued

Behaviour:
- Reset values (asynchronous): state IDLE; in_ready=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0, busy=0, done=0; word pointer, line counter and address register cleared.
- Reset mid-transfer: the partial line is lost and no SRAM write occurs. The cycle after RST deasserts is IDLE.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE: start=1 latches base_addr into the address register and num_lines into the remaining-line count.
  - If num_lines==0, go to DONE; otherwise go to FILL.
  - start is ignored in every non-IDLE state.
- FILL:
  - in_ready=1.
  - A handshake (in_valid&&in_ready) stores in_data into lane ptr, where lane k occupies bits [k*IN_W +: IN_W]. Word 0 is the LSBs.
  - ptr increments on each handshake. On the handshake with ptr==WORDS-1, ptr wraps to 0 and the next state is WRITE.
  - in_valid low means hold; no timeout.
- WRITE (exactly 1 cycle):
  - in_ready=0; sram_cen=0, sram_wen=0, sram_a=address register, sram_d=packed line.
  - The SRAM captures the write at the next rising edge.
  - On exit, the address increments modulo 2^ADDR_W (2047 wraps to 0) and the remaining count decrements.
  - If the remaining count was 1, go to DONE; else go to FILL.
- In all states other than WRITE: sram_cen=1 and sram_wen=1. sram_a and sram_d hold their last values.
- DONE (1 cycle): done=1, in_ready=0, then go to IDLE.
- Latency: the SRAM write strobe is visible on the cycle after the 4th word handshake.
- Throughput: max 4 words per 5 cycles.
- abort=1 in FILL, WRITE or DONE:
  - Next state is IDLE, ptr=0, no done pulse.
  - abort in the WRITE cycle does not suppress that cycle's already-registered strobe.
  - abort has priority over start and over handshakes in the same cycle.
- num_lines > 2048 is legal; the address wraps and earlier lines are overwritten.
- The read path is not driven by this block. The SRAM is owned exclusively while busy=1, and an external mux selects this block while busy.

Decomposition:
- Shared package (sram_pkg):
  - constants SRAM_ADDR_W=11, SRAM_LINE_W=128, SRAM_DEPTH=2048
  - FSM state enum packer_state_t {IDLE, FILL, WRITE, DONE}
- Optional single sub-module sram_line_packer_lanes: a WORDS-lane shift/lane-write register with a ptr counter and a line_full flag.
- The top level keeps the FSM, address counter and line counter.

Test Plan:
- Basic: base_addr=5, num_lines=2, words 0x00000001..0x00000008 with in_valid held high.
  - Writes A=5 D=0x00000004_00000003_00000002_00000001 and A=6 D=0x...08_07_06_05.
  - done pulses once, the cycle after the second write strobe.
- Backpressure/gaps: in_valid toggles 1,0,1,0.
  - Words are accepted only on handshakes.
  - in_ready=0 during WRITE; a word offered then is held and accepted in the next FILL cycle.
- Wrap: base_addr=2047, num_lines=2 → writes at A=2047 then A=0.
- Zero count: num_lines=0 → IDLE→DONE→IDLE, done=1 for one cycle, sram_cen never low.
- Abort after 2 words of line 1 → IDLE, busy=0, no write, no done. A new start at base_addr=10 begins a fresh line at lane 0.
- Async RST asserted mid-FILL (between clock edges) → outputs go to reset values immediately. start sampled during busy is confirmed ignored.
